// File: rtl/ram_sweep_ctrl.sv
// Sweep controller for the single-port lattice RAM. Streams every burst out to the
// compute stage, takes the results back and writes them in place, sharing the one
// RAM port between the outgoing read stream and the returning write stream.
module ram_sweep_ctrl #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned DEPTH         = 2500,
  parameter int unsigned LANES         = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [DATA_WIDTH*LANES-1:0]      rd_data_o,
  output logic                             rd_valid_o,
  input  logic                             rd_ready_i,
  input  logic [DATA_WIDTH*LANES-1:0]      wr_data_i,
  input  logic                             wr_valid_i,
  output logic                             wr_ready_o,
  output logic [ADDRESS_WIDTH-1:0]         ram_addr_o,
  output logic                             ram_write_en_o,
  output logic [DATA_WIDTH*LANES-1:0]      ram_data_in_o,
  input  logic [DATA_WIDTH*LANES-1:0]      ram_data_out_i
);

  localparam int unsigned BurstW = DATA_WIDTH * LANES;
  localparam int unsigned Bursts = DEPTH / LANES;
  localparam int unsigned CntW   = $clog2(Bursts + 1);

  if ((DEPTH % LANES) != 0) begin : gen_depth_check
    $error("DEPTH must be a multiple of LANES");
  end

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  state_e                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] rd_ptr_q, wr_ptr_q, addr_q;
  logic [CntW-1:0]          rd_issued_q, rd_delivered_q, wr_cnt_q;
  logic                     inflight_q;
  logic [BurstW-1:0]        fifo_mem_q [2];
  logic                     fifo_rd_idx_q, fifo_wr_idx_q;
  logic [1:0]               fifo_cnt_q;

  logic                     sweep, rd_valid, pop, wr_ready, wr_fire, rd_issue;
  logic [2:0]               occupancy;
  logic [ADDRESS_WIDTH-1:0] ram_addr;

  // Handshakes and port arbitration; an accepted write always takes the port.
  always_comb begin
    sweep     = (state_q == StSweep);
    rd_valid  = (fifo_cnt_q != 2'd0);
    pop       = rd_valid && rd_ready_i;
    // A result is only taken once its source burst has left, so no unread cell is hit.
    wr_ready  = sweep && (wr_cnt_q < rd_delivered_q);
    wr_fire   = wr_valid_i && wr_ready;
    // Reads are throttled so the in-flight word always has a FIFO slot to land in.
    occupancy = 3'(fifo_cnt_q) + 3'(inflight_q) - 3'(pop);
    rd_issue  = sweep && !wr_fire && (rd_issued_q < CntW'(Bursts)) && (occupancy < 3'd2);
    if (wr_fire) begin
      ram_addr = wr_ptr_q;
    end else if (rd_issue) begin
      ram_addr = rd_ptr_q;
    end else begin
      ram_addr = addr_q;
    end
  end

  assign busy_o         = sweep;
  assign done_o         = (state_q == StDone);
  assign rd_valid_o     = rd_valid;
  assign rd_data_o      = rd_valid ? fifo_mem_q[fifo_rd_idx_q] : '0;
  assign wr_ready_o     = wr_ready;
  assign ram_addr_o     = ram_addr;
  assign ram_write_en_o = wr_fire;
  assign ram_data_in_o  = wr_fire ? wr_data_i : '0;

  // Next-state logic for the sweep FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StSweep;
      StSweep: if (wr_fire && (wr_cnt_q == CntW'(Bursts - 1))) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, pointers, counters and FIFO bookkeeping; counters sit at zero while idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      inflight_q     <= 1'b0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      rd_issued_q    <= '0;
      rd_delivered_q <= '0;
      wr_cnt_q       <= '0;
      fifo_rd_idx_q  <= 1'b0;
      fifo_wr_idx_q  <= 1'b0;
      fifo_cnt_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= ram_addr;
      inflight_q <= rd_issue;
      if (state_q == StIdle) begin
        rd_ptr_q       <= '0;
        wr_ptr_q       <= '0;
        rd_issued_q    <= '0;
        rd_delivered_q <= '0;
        wr_cnt_q       <= '0;
      end else begin
        if (rd_issue) begin
          rd_ptr_q    <= rd_ptr_q + ADDRESS_WIDTH'(LANES);
          rd_issued_q <= rd_issued_q + 1'b1;
        end
        if (pop) begin
          rd_delivered_q <= rd_delivered_q + 1'b1;
        end
        if (wr_fire) begin
          wr_ptr_q <= wr_ptr_q + ADDRESS_WIDTH'(LANES);
          wr_cnt_q <= wr_cnt_q + 1'b1;
        end
      end
      if (inflight_q) begin
        fifo_wr_idx_q <= ~fifo_wr_idx_q;
      end
      if (pop) begin
        fifo_rd_idx_q <= ~fifo_rd_idx_q;
      end
      fifo_cnt_q <= fifo_cnt_q + 2'(inflight_q) - 2'(pop);
    end
  end

  // Burst storage; the RAM word read last cycle lands here.
  always_ff @(posedge clk_i) begin
    if (inflight_q) begin
      fifo_mem_q[fifo_wr_idx_q] <= ram_data_out_i;
    end
  end

endmodule

// File: tb/tb_ram_sweep_ctrl.sv
// Directed bench for ram_sweep_ctrl with a RAM model and an echo (+1 per lane) consumer.
module tb_ram_sweep_ctrl;
  localparam int DW     = 32;
  localparam int AW     = 12;
  localparam int DEPTH  = 2500;
  localparam int LANES  = 4;
  localparam int BURSTS = 625;
  localparam int BW     = DW * LANES;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, rd_valid, rd_ready, wr_valid, wr_ready;
  logic [BW-1:0] rd_data, wr_data, ram_data_in, ram_data_out;
  logic [AW-1:0] ram_addr;
  logic          ram_write_en;

  always #5 clk = ~clk;

  ram_sweep_ctrl #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH), .LANES(LANES)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
    .rd_data_o(rd_data), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .ram_addr_o(ram_addr), .ram_write_en_o(ram_write_en),
    .ram_data_in_o(ram_data_in), .ram_data_out_i(ram_data_out)
  );

  // RAM model: LANES words per access, one-cycle read latency.
  logic [DW-1:0] mem [DEPTH];
  logic          load_en;
  always @(posedge clk) begin
    if (load_en) begin
      for (int a = 0; a < DEPTH; a++) mem[a] <= DW'(a);
    end else if (ram_write_en) begin
      for (int i = 0; i < LANES; i++) mem[int'(ram_addr) + i] <= ram_data_in[i*DW +: DW];
    end
    for (int i = 0; i < LANES; i++) ram_data_out[i*DW +: DW] <= mem[int'(ram_addr) + i];
  end

  logic [DW-1:0] gold [DEPTH];
  logic [BW-1:0] res_q [$];
  int total, bad, cyc, pops, wacc, done_cnt, err_rd, err_wr, err_rdy, err_stall, rdy_mode;
  logic wv_en, prev_stall;
  logic [BW-1:0] prev_data;
  logic s_busy, s_done, s_rd_valid, s_wr_ready, s_we;
  logic [AW-1:0] s_addr;
  logic [BW-1:0] s_rd_data, s_din;

  function automatic logic [BW-1:0] gold_burst(input int k);
    logic [BW-1:0] b;
    for (int i = 0; i < LANES; i++) b[i*DW +: DW] = gold[k*LANES + i];
    return b;
  endfunction

  function automatic logic [BW-1:0] plus1(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = b[i*DW +: DW] + 1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, score handshakes, then drive inputs after the edge.
  task automatic step();
    logic pop, wfire;
    @(negedge clk);
    s_busy = busy; s_done = done; s_rd_valid = rd_valid; s_rd_data = rd_data;
    s_wr_ready = wr_ready; s_we = ram_write_en; s_addr = ram_addr; s_din = ram_data_in;
    pop   = rd_valid && rd_ready;
    wfire = wr_valid && wr_ready;
    if (wr_ready !== (busy && (wacc < pops))) err_rdy++;
    if (ram_write_en !== wfire) err_wr++;
    if (wfire && ((ram_addr !== AW'(wacc * LANES)) || (ram_data_in !== wr_data))) err_wr++;
    if (prev_stall && (!rd_valid || (rd_data !== prev_data))) err_stall++;
    prev_stall = rd_valid && !rd_ready && !rst;
    prev_data  = rd_data;
    if (pop) begin
      if (rd_data !== gold_burst(pops)) err_rd++;
      res_q.push_back(plus1(rd_data));
      pops++;
    end
    if (done) done_cnt++;
    cyc++;
    @(posedge clk);
    #1;
    if (wfire) begin
      res_q.delete(0);
      wacc++;
    end
    wr_data  = (res_q.size() > 0) ? res_q[0] : {LANES{32'hbad0_0000}};
    wr_valid = wv_en;
    case (rdy_mode)
      0:       rd_ready = 1'b1;
      1:       rd_ready = ((cyc % 3) == 0);
      default: rd_ready = 1'b0;
    endcase
  endtask

  task automatic clear_counts();
    pops = 0; wacc = 0; done_cnt = 0; prev_stall = 1'b0;
    err_rd = 0; err_wr = 0; err_rdy = 0; err_stall = 0;
    res_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_done(input string tag, input int budget, output int ncyc);
    int n = 0;
    while (!s_done && n < budget) begin
      step();
      n++;
    end
    ncyc = n;
    chk({tag, " done seen"}, BW'(s_done), BW'(1));
  endtask

  task automatic chk_sweep(input string tag);
    chk({tag, " pops"}, BW'(pops), BW'(BURSTS));
    chk({tag, " writes"}, BW'(wacc), BW'(BURSTS));
    chk({tag, " rd_data order"}, BW'(err_rd), '0);
    chk({tag, " write port"}, BW'(err_wr), '0);
    chk({tag, " wr_ready"}, BW'(err_rdy), '0);
    chk({tag, " rd stall"}, BW'(err_stall), '0);
    chk({tag, " busy at done"}, BW'(s_busy), '0);
    step();
    step();
    chk({tag, " busy after"}, BW'(s_busy), '0);
    chk({tag, " done count"}, BW'(done_cnt), BW'(1));
  endtask

  task automatic chk_mem(input string tag);
    int e = 0;
    for (int a = 0; a < DEPTH; a++) if (mem[a] !== gold[a]) e++;
    chk({tag, " ram contents"}, BW'(e), '0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " busy"}, BW'(s_busy), '0);
    chk({tag, " done"}, BW'(s_done), '0);
    chk({tag, " rd_valid"}, BW'(s_rd_valid), '0);
    chk({tag, " wr_ready"}, BW'(s_wr_ready), '0);
    chk({tag, " ram_write_en"}, BW'(s_we), '0);
    chk({tag, " ram_addr"}, BW'(s_addr), '0);
    chk({tag, " ram_data_in"}, s_din, '0);
    chk({tag, " rd_data"}, s_rd_data, '0);
  endtask

  initial begin
    int n;
    total = 0; bad = 0; cyc = 0;
    clear_counts();
    rst = 1'b1; start = 1'b0; rd_ready = 1'b0; rdy_mode = 2;
    wv_en = 1'b1; wr_valid = 1'b1; wr_data = {LANES{32'hdeadbeef}};
    load_en = 1'b1;
    for (int a = 0; a < DEPTH; a++) gold[a] = DW'(a);
    @(posedge clk); #1; load_en = 1'b0;
    @(posedge clk); #1;
    step();
    chk_reset_vals("reset");

    // Sweep 1: echo consumer, ready always high, wr_valid high from start+1.
    rst = 1'b0; rdy_mode = 0; rd_ready = 1'b1;
    step();
    pulse_start();
    chk("c0 busy", BW'(s_busy), '0);
    step();
    chk("c1 busy", BW'(s_busy), BW'(1));
    chk("c1 read addr", BW'(s_addr), '0);
    chk("c1 no write", BW'(s_we), '0);
    step();
    chk("c2 rd_valid", BW'(s_rd_valid), '0);
    step();
    chk("c3 rd_valid", BW'(s_rd_valid), BW'(1));
    chk("c3 rd_data", s_rd_data, gold_burst(0));
    chk("c3 wr_ready", BW'(s_wr_ready), '0);
    step();
    chk("c4 write wins", BW'(s_we), BW'(1));
    chk("c4 write addr", BW'(s_addr), '0);
    chk("c4 write data", s_din, plus1(gold_burst(0)));
    step();
    step();
    chk("c6 write addr", BW'(s_addr), BW'(8));
    step();
    chk("c7 read next free", BW'(s_we), '0);
    chk("c7 read addr", BW'(s_addr), BW'(12));
    run_to_done("s1", 3000, n);
    chk("s1 sweep length", BW'((n + 7 >= 1250) && (n + 7 <= 1320)), BW'(1));
    chk_sweep("s1");
    for (int a = 0; a < DEPTH; a++) gold[a] = gold[a] + 1;
    chk_mem("s1");

    // Sweep 2: stalled consumer first, then ready 1-of-3, start pulsed at burst 100.
    clear_counts();
    rdy_mode = 2; rd_ready = 1'b0;
    pulse_start();
    repeat (12) step();
    chk("s2 stalled rd_valid", BW'(s_rd_valid), BW'(1));
    chk("s2 stalled rd_data", s_rd_data, gold_burst(0));
    chk("s2 no early wr_ready", BW'(s_wr_ready), '0);
    rdy_mode = 1;
    n = 0;
    while (pops < 100 && n < 2000) begin
      step();
      n++;
    end
    chk("s2 reach burst 100", BW'(pops), BW'(100));
    pulse_start();
    chk("s2 start ignored busy", BW'(s_busy), BW'(1));
    step();
    chk("s2 still busy", BW'(s_busy), BW'(1));
    chk("s2 no early done", BW'(done_cnt), '0);
    run_to_done("s2", 5000, n);
    chk_sweep("s2");
    for (int a = 0; a < DEPTH; a++) gold[a] = gold[a] + 1;
    chk_mem("s2");

    // Sweep 3: reset after 300 writes, then a fresh sweep from address 0.
    clear_counts();
    rdy_mode = 0; rd_ready = 1'b1;
    pulse_start();
    n = 0;
    while (wacc < 300 && n < 2000) begin
      step();
      n++;
    end
    chk("s3 reach 300 writes", BW'(wacc), BW'(300));
    rst = 1'b1; wv_en = 1'b0; wr_valid = 1'b0; rdy_mode = 2; rd_ready = 1'b0;
    step();
    rst = 1'b0; wv_en = 1'b1; wr_valid = 1'b1;
    step();
    chk_reset_vals("post rst");
    for (int a = 0; a < DEPTH; a++) if ((a / LANES) < wacc) gold[a] = gold[a] + 1;
    chk_mem("s3 partial");

    clear_counts();
    rdy_mode = 0; rd_ready = 1'b1;
    pulse_start();
    step();
    chk("s4 busy", BW'(s_busy), BW'(1));
    chk("s4 restart addr", BW'(s_addr), '0);
    run_to_done("s4", 3000, n);
    chk_sweep("s4");
    for (int a = 0; a < DEPTH; a++) gold[a] = gold[a] + 1;
    chk_mem("s4");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
